// File: rtl/rll_prio_intc_seq.sv
// rll_prio_intc_seq: key-gated N-channel priority interrupt controller with
// serially loaded key, pending latch and a valid/ready offer FSM.
module rll_prio_intc_seq #(
  parameter int N_CH = 9,
  parameter int KEY_W = 8,
  parameter logic [KEY_W-1:0] KEY_CORRECT = 8'hA5,
  parameter int MODE = 0,
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            key_in,
  input  logic            key_shift,
  input  logic            key_commit,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ready,
  output logic [N_CH-1:0] pend,
  output logic            key_loaded,
  output logic            key_err
);
  localparam int CW = $clog2(KEY_W + 1);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t            r_state;
  logic [KEY_W-1:0]  r_key_sr;
  logic [KEY_W-1:0]  r_key_reg;
  logic [CW-1:0]     r_cnt;
  logic [N_CH-1:0]   r_pend;
  logic              r_valid;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_rr;
  logic              r_loaded;
  logic              r_err;
  logic [N_CH-1:0]   w_req_eff;
  logic [N_CH-1:0]   w_clr;
  logic              w_accept;
  logic [ID_W-1:0]   w_sel;
  int                w_base;
  for (genvar i = 0; i < N_CH; i++) begin : g_gate
    assign w_req_eff[i] = req[i] ^ r_key_reg[i % KEY_W] ^ KEY_CORRECT[i % KEY_W];
  end
  assign w_accept = r_valid & irq_ready;
  assign w_clr    = w_accept ? (N_CH'(1) << r_id) : '0;
  assign w_base   = (MODE != 0) ? int'(r_rr) : 0;
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_sel = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (r_pend[(w_base + k) % N_CH]) w_sel = ID_W'((w_base + k) % N_CH);
  end
  // Commit sees the pre-shift counter and register; a same-cycle shift is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_sr  <= '0;
      r_key_reg <= '0;
      r_cnt     <= '0;
      r_loaded  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (key_commit) begin
        r_cnt <= '0;
        if (r_cnt == CW'(KEY_W)) begin
          r_key_reg <= r_key_sr;
          r_loaded  <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end else if (key_shift) begin
        r_key_sr <= {r_key_sr[KEY_W-2:0], key_in};
        r_cnt    <= (r_cnt == CW'(KEY_W)) ? r_cnt : r_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_clr) | w_req_eff;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_rr    <= '0;
    end else begin
      case (r_state)
        IDLE: if (|r_pend) begin
          r_id    <= w_sel;
          r_valid <= 1'b1;
          r_state <= OFFER;
        end
        OFFER: if (irq_ready) begin
          r_valid <= 1'b0;
          r_rr    <= (r_id == ID_W'(N_CH - 1)) ? '0 : r_id + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign irq_valid  = r_valid;
  assign irq_id     = r_id;
  assign pend       = r_pend;
  assign key_loaded = r_loaded;
  assign key_err    = r_err;
endmodule

// File: tb/tb_rll_prio_intc_seq.sv
// tb_rll_prio_intc_seq: directed checks of key loading, pending, offer
// handshake, fixed and round-robin selection and async reset.
module tb_rll_prio_intc_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] req = '0;
  logic       key_in = 1'b0;
  logic       key_shift = 1'b0;
  logic       key_commit = 1'b0;
  logic       irq_ready = 1'b0;
  logic       v0, v1, kl0, kl1, ke0, ke1;
  logic [3:0] id0, id1;
  logic [8:0] p0, p1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rll_prio_intc_seq #(.N_CH(9), .KEY_W(8), .KEY_CORRECT(8'hA5), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .key_in(key_in), .key_shift(key_shift),
    .key_commit(key_commit), .irq_valid(v0), .irq_id(id0), .irq_ready(irq_ready),
    .pend(p0), .key_loaded(kl0), .key_err(ke0));

  rll_prio_intc_seq #(.N_CH(9), .KEY_W(8), .KEY_CORRECT(8'hA5), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .key_in(key_in), .key_shift(key_shift),
    .key_commit(key_commit), .irq_valid(v1), .irq_id(id1), .irq_ready(irq_ready),
    .pend(p1), .key_loaded(kl1), .key_err(ke1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; key_shift = 0; key_commit = 0; irq_ready = 0;
    rst_n = 0;
    #3;
    rst_n = 1;
    tick();
  endtask

  task automatic load_key(input logic [7:0] k, input int n);
    for (int b = 0; b < n; b++) begin
      key_shift = 1; key_in = k[7-b];
      tick();
    end
    key_shift = 0; key_commit = 1;
    tick();
    key_commit = 0;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    irq_ready = 1;
    while (!(p0 == 9'h000 && v0 == 1'b0) && n < 40) begin
      tick();
      n++;
    end
    irq_ready = 0;
    checks++;
    if (p0 !== 9'h000 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL drain: pend=%h valid=%b, required pend=000 valid=0", p0, v0);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; req = '0;
    #12;
    checks++;
    if (p0 !== 9'h000 || v0 !== 1'b0 || id0 !== 4'd0 || kl0 !== 1'b0 || ke0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pend=%h valid=%b id=%0d loaded=%b err=%b, required 000/0/0/0/0", p0, v0, id0, kl0, ke0);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (p0 !== 9'h1A5 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL nokey_pend: pend=%h valid=%b, required 1a5/0", p0, v0);
    end
    tick();
    checks++;
    if (v0 !== 1'b1 || id0 !== 4'd0 || kl0 !== 1'b0) begin
      errors++;
      $display("FAIL nokey_offer: valid=%b id=%0d loaded=%b, required 1/0/0", v0, id0, kl0);
    end
  endtask

  task automatic test_key_load();
    load_key(8'hA5, 8);
    checks++;
    if (kl0 !== 1'b1 || ke0 !== 1'b0) begin
      errors++;
      $display("FAIL key_commit: loaded=%b err=%b, required 1/0", kl0, ke0);
    end
    drain0();
    req = 9'h010;
    tick();
    req = '0;
    checks++;
    if (p0 !== 9'h010 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL req4_pend: pend=%h valid=%b, required 010/0", p0, v0);
    end
    tick();
    checks++;
    if (v0 !== 1'b1 || id0 !== 4'd4) begin
      errors++;
      $display("FAIL req4_offer: valid=%b id=%0d, required 1/4", v0, id0);
    end
    irq_ready = 1;
    tick();
    irq_ready = 0;
    checks++;
    if (p0 !== 9'h000 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL req4_accept: pend=%h valid=%b, required 000/0", p0, v0);
    end
  endtask

  task automatic test_key_err();
    do_reset();
    load_key(8'hFF, 5);
    checks++;
    if (ke0 !== 1'b1 || kl0 !== 1'b0) begin
      errors++;
      $display("FAIL short_commit: err=%b loaded=%b, required 1/0", ke0, kl0);
    end
    tick();
    checks++;
    if (ke0 !== 1'b0 || p0 !== 9'h1A5) begin
      errors++;
      $display("FAIL short_after: err=%b pend=%h, required 0/1a5", ke0, p0);
    end
  endtask

  task automatic test_hold();
    do_reset();
    load_key(8'hA5, 8);
    drain0();
    req = 9'h003;
    tick();
    req = '0;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (v0 !== 1'b1 || id0 !== 4'd0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b id=%0d, required 1/0", c, v0, id0);
      end
    end
    irq_ready = 1;
    tick();
    irq_ready = 0;
    checks++;
    if (v0 !== 1'b0 || p0 !== 9'h002) begin
      errors++;
      $display("FAIL hold_accept: valid=%b pend=%h, required 0/002", v0, p0);
    end
    tick();
    checks++;
    if (v0 !== 1'b1 || id0 !== 4'd1) begin
      errors++;
      $display("FAIL hold_next: valid=%b id=%0d, required 1/1", v0, id0);
    end
    irq_ready = 1;
    tick();
    irq_ready = 0;
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    load_key(8'hA5, 8);
    req = 9'h1FF;
    irq_ready = 1;
    for (int k = 0; k < 11; k++) begin
      n = 0;
      while (v1 !== 1'b1 && n < 4) begin
        tick();
        n++;
      end
      checks++;
      if (v1 !== 1'b1 || id1 !== 4'(k % 9)) begin
        errors++;
        $display("FAIL rr_%0d: valid=%b id=%0d, required 1/%0d", k, v1, id1, k % 9);
      end
      tick();
    end
    irq_ready = 0;
    req = '0;
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    load_key(8'hA5, 8);
    drain0();
    req = 9'h008;
    tick();
    req = '0;
    tick();
    checks++;
    if (v0 !== 1'b1 || id0 !== 4'd3) begin
      errors++;
      $display("FAIL mid_offer: valid=%b id=%0d, required 1/3", v0, id0);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (v0 !== 1'b0 || p0 !== 9'h000 || kl0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b pend=%h loaded=%b, required 0/000/0", v0, p0, kl0);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (p0 !== 9'h1A5 || kl0 !== 1'b0) begin
      errors++;
      $display("FAIL key_cleared: pend=%h loaded=%b, required 1a5/0", p0, kl0);
    end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_key_err();
    test_hold();
    test_round_robin();
    test_reset_mid_offer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rll_prio_intc_seq.md
Name: rll_prio_intc_seq

Overview:
- Parametrised, sequential, logic-locked priority interrupt controller for the obfuscated-circuit suite. It is a clocked, N-channel successor to the combinational locked priority channel circuits.
- Request inputs pass through per-bit key gates driven by a serially loaded key register. Effective requests are latched as pending and arbitrated with fixed or round-robin priority. One winner is offered at a time over a valid/ready handshake.
- With a wrong key the block keeps running and produces corrupted grants. Outputs are never suppressed. The block is a target for sequential SAT/unrolling attacks.

Parameters:
- N_CH, 9, number of interrupt channels (2..64).
- KEY_W, 8, key length in bits (2..32). Channel i is keyed by key bit i mod KEY_W.
- KEY_CORRECT, 8'hA5, KEY_W-bit correct key (hidden constant).
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins); 1 = round-robin.
- ID_W, derived localparam = max(1, clog2(N_CH)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_CH  level interrupt requests, one per channel.
- key_in  in  1  serial key bit, MSB first.
- key_shift  in  1  shift key_in into the key shift register this cycle.
- key_commit  in  1  transfer the shift register into the active key register.
- irq_valid  out  1  an interrupt is offered.
- irq_id  out  ID_W  offered channel index.
- irq_ready  in  1  consumer accepts the offered interrupt.
- pend  out  N_CH  pending vector (registered).
- key_loaded  out  1  a legal commit has occurred since reset.
- key_err  out  1  one-cycle pulse: illegal commit.

Behaviour:
- Reset (async assert, sync release) clears: key_sr=0, key_reg=0, shift counter=0, pend=0, irq_valid=0, irq_id=0, rr pointer=0, key_loaded=0, key_err=0. The FSM goes to IDLE.
- Key gate: req_eff[i] = req[i] XOR key_reg[i%KEY_W] XOR KEY_CORRECT[i%KEY_W]. Combinational; the correct key gives req_eff = req.
- Key load:
  - key_shift: key_sr <= {key_sr[KEY_W-2:0], key_in}; the counter saturates at KEY_W.
  - key_commit with counter == KEY_W: key_reg <= key_sr, counter <= 0, key_loaded <= 1.
  - key_commit with counter != KEY_W: key_reg unchanged, counter <= 0, key_err pulses for 1 cycle.
  - key_shift and key_commit in the same cycle: commit evaluates the pre-shift counter and key_sr; the shift is discarded.
  - key_reg changes take effect on req_eff the cycle after commit. Key loading never disturbs an offer in progress.
- Pending: each cycle pend <= (pend & ~clr) | req_eff.
  - clr is the one-hot of irq_id when irq_valid & irq_ready.
  - If set and clear hit the same bit, set wins.
- FSM, two states:
  - IDLE: if pend != 0, select a winner, register irq_id, set irq_valid=1, go to OFFER. Otherwise stay.
  - OFFER: hold irq_valid=1 and irq_id stable while irq_ready=0. On irq_ready=1, clear irq_valid and go to IDLE. The earliest next offer is 1 cycle later.
- Selection:
  - MODE=0: lowest set index of pend.
  - MODE=1: first set index at or after rr_ptr, wrapping at N_CH-1 -> 0. On accept, rr_ptr <= irq_id+1, wrapping N_CH -> 0.
- Latency: req edge at cycle t -> pend bit at t+1 -> irq_valid at t+2 (if IDLE).
- Reset mid-offer drops the offer immediately (asynchronously); pending requests are lost.

Test Plan:
- Reset, no key, req=0: after 1 cycle pend=9'h1A5 (bits 0,2,5,7,8); at t+2 irq_valid=1, irq_id=0; key_loaded=0.
- Shift A5 MSB-first over 8 cycles, then commit: key_loaded=1, no key_err. Accept pending entries until pend=0. Then req=9'h010 for 1 cycle -> irq_valid 2 cycles later with irq_id=4; pend clears on accept.
- 5 shifts then commit: key_err=1 for exactly 1 cycle, key_reg unchanged (pend keeps 9'h1A5 corruption pattern with req=0).
- MODE=0, correct key, req=9'h003 for 1 cycle, irq_ready low 3 cycles: irq_id=0 held stable 3 cycles; accept -> next offer irq_id=1 after one IDLE cycle.
- MODE=1, correct key, req=9'h1FF held, irq_ready=1: accepted ids 0,1,...,8,0,1 in order.
- Assert rst_n=0 mid-OFFER (irq_id=3): irq_valid and pend go to 0 before the next clock edge. After release, key_loaded=0 and key_reg=0.
